dp_latency_ram: RTL and testbench
=================================

DP_LATENCY_RAM -- requirements
Module: dp_latency_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 22; byte-address width; memory depth is 2^(ADDR_WIDTH-2) 32-bit words.
REQ-002 Parameter INSTR_RDATA_WIDTH, default 128; instruction fetch width; legal values are 32, 64 and 128.
REQ-003 Parameter INSTR_LATENCY, default 1; grant-to-rvalid delay in cycles on the instruction port; legal range is 1..4.
REQ-004 Parameter DATA_LATENCY, default 1; grant-to-rvalid delay in cycles on the data port; legal range is 1..4.
REQ-005 Parameter LFSR_SEED, default 16'hACE1; reset seed of the stall generators.
REQ-006 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-007 rstn_i  in  1  asynchronous, active-low reset.
REQ-008 stall_en_i  in  1  enables random grant stalls when the stall feature is compiled in.
REQ-009 instr_req_i  in  1 / instr_addr_i  in  ADDR_WIDTH / instr_gnt_o  out  1 / instr_rvalid_o  out  1 / instr_rdata_o  out  INSTR_RDATA_WIDTH: instruction fetch port.
REQ-010 data_req_i  in  1 / data_addr_i  in  ADDR_WIDTH / data_we_i  in  1 / data_be_i  in  4 / data_wdata_i  in  32 / data_gnt_o  out  1 / data_rvalid_o  out  1 / data_rdata_o  out  32: load/store port.

Function
REQ-011 gnt_o SHALL be combinational: gnt_o = req_i AND NOT stall for that port; a request is accepted in any cycle where req_i and gnt_o are both 1.
REQ-012 Each port SHALL accept one request per cycle, fully pipelined, with no back-pressure on rvalid.
REQ-013 rvalid_o SHALL assert exactly LATENCY cycles after acceptance, for one cycle per accepted request, with responses in acceptance order.
REQ-014 Instruction reads SHALL return the INSTR_RDATA_WIDTH-aligned block containing instr_addr_i; the lowest address occupies the LSBs.
REQ-015 Data reads SHALL return the aligned word; data_addr_i[1:0] SHALL be ignored.
REQ-016 Data writes SHALL update only the bytes selected by data_be_i, at the acceptance edge.
REQ-017 Data writes SHALL still produce an rvalid after DATA_LATENCY cycles, with data_rdata_o = 0.
REQ-018 Memory read data SHALL be sampled at the acceptance edge; rdata SHALL be held in the latency pipeline until rvalid.
REQ-019 When a data write and a read on either port hit the same word in the same cycle, the read SHALL return the pre-write value.
REQ-020 A data read accepted one cycle after a write SHALL return the written value.
REQ-021 Addresses SHALL wrap modulo the memory depth; there is no error response.
REQ-022 rdata_o SHALL be 0 whenever rvalid_o is 0.

Reset
REQ-023 Asserting rstn_i SHALL asynchronously clear all pipeline valid bits and drive rvalid_o=0 and rdata_o=0; gnt_o then follows REQ-011 with stall=0.
REQ-024 Responses in flight when rstn_i asserts SHALL be discarded and SHALL NOT be produced after reset release.
REQ-025 Memory contents SHALL NOT be reset.
REQ-026 The LFSRs SHALL reset to LFSR_SEED (instruction port) and to LFSR_SEED with all bits inverted (data port).

Configuration
REQ-027 Macro DP_RAM_RANDOM_STALL_EN SHALL control whether the stall generators are compiled in.
REQ-028 With DP_RAM_RANDOM_STALL_EN defined, each port SHALL have a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle.
REQ-029 With the macro defined, stall for a port SHALL be stall_en_i AND (lfsr[1:0]==2'b00).
REQ-030 Without the macro, stall SHALL be tied to 0, stall_en_i SHALL be unused and no LFSR flops SHALL exist.

Structure
REQ-031 Package dp_ram_pkg SHALL hold the LFSR width, LFSR taps, default seed, and the maximum-latency constant 4.
REQ-032 The block SHALL use one sub-module, dp_ram_lat_pipe (parametrised width and depth valid/data shift pipeline), instantiated once per port.

Verification
REQ-033 Write 0xDEADBEEF to 0x100 with be=4'hF, then read 0x100 -> data_rvalid_o after DATA_LATENCY cycles with rdata 0xDEADBEEF.
REQ-034 Write 0x000000AA to 0x100 with be=4'b0001 over existing 0xDEADBEEF, then read -> 0xDEADBEAA.
REQ-035 INSTR_RDATA_WIDTH=128, INSTR_LATENCY=3, back-to-back fetches 0x80 and 0x90 -> rvalid on cycles +3 and +4, each returning its 16-byte block in order.
REQ-036 Same-cycle data write and instruction read of 0x200 (old value 0x11111111, new 0x22222222) -> instruction read returns 0x11111111; a later read returns 0x22222222.
REQ-037 Assert rstn_i with two responses in flight -> rvalid_o stays 0 after reset release.
REQ-038 With DP_RAM_RANDOM_STALL_EN defined, stall_en_i=1 and 1000 continuous requests -> grant rate 70-80% and every granted request answered exactly once; with stall_en_i=0 -> 100% grant.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared constants for dp_latency_ram: stall-LFSR geometry, default seed, latency ceiling.
package dp_ram_pkg;

  localparam int                LFSR_W            = 16;
  // Taps 16,14,13,11 (1-based) as a mask over bits [15:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam int                MAX_LATENCY       = 4;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dp_ram_lat_pipe.sv
// Fixed-depth valid/data shift pipeline; output is DEPTH cycles behind input, never stalls.
// Valid bits reset asynchronously; data is zeroed at the output whenever valid is low.
module dp_ram_lat_pipe
  import dp_ram_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             in_vld_i,
  input  logic [WIDTH-1:0] in_dat_i,
  output logic             out_vld_o,
  output logic [WIDTH-1:0] out_dat_o
);

  localparam int STAGES = (DEPTH < 1) ? 1 : ((DEPTH > MAX_LATENCY) ? MAX_LATENCY : DEPTH);

  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  dat_q [STAGES];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_vld_i;
      for (int i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Data needs no reset: it is only observable alongside its valid bit
  always_ff @(posedge clk_i) begin
    dat_q[0] <= in_dat_i;
    for (int i = 1; i < STAGES; i++) dat_q[i] <= dat_q[i-1];
  end

  assign out_vld_o = vld_q[STAGES-1];
  assign out_dat_o = vld_q[STAGES-1] ? dat_q[STAGES-1] : '0;

endmodule

// File: rtl/dp_latency_ram.sv
// Dual-port (fetch + load/store) RAM model with fixed per-port response latency, one request/cycle/port.
// Grant is combinational; define DP_RAM_RANDOM_STALL_EN to compile in LFSR-driven random grant stalls.
module dp_latency_ram
  import dp_ram_pkg::*;
#(
  parameter int                ADDR_WIDTH        = 22,
  parameter int                INSTR_RDATA_WIDTH = 128,
  parameter int                INSTR_LATENCY     = 1,
  parameter int                DATA_LATENCY      = 1,
  parameter logic [LFSR_W-1:0] LFSR_SEED         = LFSR_DEFAULT_SEED
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         stall_en_i,
  input  logic                         instr_req_i,
  input  logic [ADDR_WIDTH-1:0]        instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_o,
  input  logic                         data_req_i,
  input  logic [ADDR_WIDTH-1:0]        data_addr_i,
  input  logic                         data_we_i,
  input  logic [3:0]                   data_be_i,
  input  logic [31:0]                  data_wdata_i,
  output logic                         data_gnt_o,
  output logic                         data_rvalid_o,
  output logic [31:0]                  data_rdata_o
);

  localparam int                WIDX_W    = ADDR_WIDTH - 2;
  localparam int                MEM_WORDS = 1 << WIDX_W;
  localparam int                IWORDS    = INSTR_RDATA_WIDTH / 32;
  localparam logic [WIDX_W-1:0] IBLK_MASK = ~WIDX_W'(IWORDS - 1);

  logic                         instr_stall, data_stall;
  logic                         instr_acc, data_acc;
  logic [WIDX_W-1:0]            instr_base, data_widx;
  logic [INSTR_RDATA_WIDTH-1:0] instr_blk;
  logic [31:0]                  data_rd;
  logic [31:0]                  mem_q [MEM_WORDS];

`ifdef DP_RAM_RANDOM_STALL_EN
  logic [LFSR_W-1:0] instr_lfsr_q, instr_lfsr_d;
  logic [LFSR_W-1:0] data_lfsr_q, data_lfsr_d;

  assign instr_lfsr_d = lfsr_next(instr_lfsr_q);
  assign data_lfsr_d  = lfsr_next(data_lfsr_q);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      instr_lfsr_q <= LFSR_SEED;
      data_lfsr_q  <= ~LFSR_SEED;
    end else begin
      instr_lfsr_q <= instr_lfsr_d;
      data_lfsr_q  <= data_lfsr_d;
    end
  end

  // Stalls are suppressed during reset so grant simply mirrors request
  assign instr_stall = rstn_i & stall_en_i & (instr_lfsr_q[1:0] == 2'b00);
  assign data_stall  = rstn_i & stall_en_i & (data_lfsr_q[1:0] == 2'b00);
`else
  logic unused_stall_en;
  assign unused_stall_en = stall_en_i;
  assign instr_stall     = 1'b0;
  assign data_stall      = 1'b0;
`endif

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  assign instr_gnt_o = instr_req_i & ~instr_stall;
  assign data_gnt_o  = data_req_i & ~data_stall;
  assign instr_acc   = instr_gnt_o;
  assign data_acc    = data_gnt_o;

  assign instr_base  = instr_addr_i[ADDR_WIDTH-1:2] & IBLK_MASK;
  assign data_widx   = data_addr_i[ADDR_WIDTH-1:2];

  // Lowest word of the fetch block lands in the LSBs
  always_comb begin
    instr_blk = '0;
    for (int k = 0; k < IWORDS; k++) begin
      instr_blk[k*32 +: 32] = mem_q[instr_base | WIDX_W'(k)];
    end
  end

  assign data_rd = data_we_i ? 32'h0 : mem_q[data_widx];

  // Reads above sample the pre-edge array, giving read-before-write on collisions
  always_ff @(posedge clk_i) begin
    if (data_acc && data_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem_q[data_widx][b*8 +: 8] <= data_wdata_i[b*8 +: 8];
      end
    end
  end

  dp_ram_lat_pipe #(
    .WIDTH (INSTR_RDATA_WIDTH),
    .DEPTH (INSTR_LATENCY)
  ) u_instr_pipe (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .in_vld_i  (instr_acc),
    .in_dat_i  (instr_blk),
    .out_vld_o (instr_rvalid_o),
    .out_dat_o (instr_rdata_o)
  );

  dp_ram_lat_pipe #(
    .WIDTH (32),
    .DEPTH (DATA_LATENCY)
  ) u_data_pipe (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .in_vld_i  (data_acc),
    .in_dat_i  (data_rd),
    .out_vld_o (data_rvalid_o),
    .out_dat_o (data_rdata_o)
  );

endmodule

// File: tb/tb_dp_latency_ram.sv
// Randomized and directed bench for dp_latency_ram against an array/queue reference model.
module tb_dp_latency_ram;

  localparam int AW = 16;
  localparam int IW = 128;
  localparam int IL = 3;
  localparam int DL = 2;

  typedef struct {
    int           cyc;
    logic [127:0] dat;
  } resp_t;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          stall_en_i = 1'b0;
  logic          instr_req_i = 1'b0;
  logic [AW-1:0] instr_addr_i = '0;
  logic          instr_gnt_o, instr_rvalid_o;
  logic [IW-1:0] instr_rdata_o;
  logic          data_req_i = 1'b0;
  logic [AW-1:0] data_addr_i = '0;
  logic          data_we_i = 1'b0;
  logic [3:0]    data_be_i = '0;
  logic [31:0]   data_wdata_i = '0;
  logic          data_gnt_o, data_rvalid_o;
  logic [31:0]   data_rdata_o;

  logic [31:0] mm [16384];
  resp_t exp_i[$], act_i[$], exp_d[$], act_d[$];
  int cyc = 0;
  int n_cmp = 0, n_fail = 0;
  int ireq_cnt = 0, dreq_cnt = 0, ignt_cnt = 0, dgnt_cnt = 0, spurious = 0, zero_viol = 0;

  dp_latency_ram #(
    .ADDR_WIDTH        (AW),
    .INSTR_RDATA_WIDTH (IW),
    .INSTR_LATENCY     (IL),
    .DATA_LATENCY      (DL)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .stall_en_i     (stall_en_i),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    resp_t r;
    if (instr_rvalid_o) begin r.cyc = cyc; r.dat = instr_rdata_o; act_i.push_back(r); end
    else if (instr_rdata_o != '0) zero_viol++;
    if (data_rvalid_o) begin r.cyc = cyc; r.dat = {96'b0, data_rdata_o}; act_d.push_back(r); end
    else if (data_rdata_o != '0) zero_viol++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One bus cycle: drive, sample grants before the edge, update the reference model
  task automatic drive(input logic ir, input logic [15:0] ia, input logic dr, input logic we,
                       input logic [3:0] be, input logic [15:0] da, input logic [31:0] wd);
    resp_t r;
    int wi, bi;
    @(negedge clk);
    instr_req_i = ir; instr_addr_i = ia;
    data_req_i = dr; data_we_i = we; data_be_i = be; data_addr_i = da; data_wdata_i = wd;
    #2;
    if (ir) ireq_cnt++;
    if (dr) dreq_cnt++;
    if ((instr_gnt_o && !ir) || (data_gnt_o && !dr)) spurious++;
    if (ir && instr_gnt_o) begin
      ignt_cnt++;
      bi = int'(ia[15:4]) * 4;
      r.cyc = cyc + IL;
      r.dat = {mm[bi+3], mm[bi+2], mm[bi+1], mm[bi]};
      exp_i.push_back(r);
    end
    if (dr && data_gnt_o) begin
      dgnt_cnt++;
      wi = int'(da[15:2]);
      r.cyc = cyc + DL;
      r.dat = we ? 128'b0 : {96'b0, mm[wi]};
      exp_d.push_back(r);
      if (we) for (int b = 0; b < 4; b++) if (be[b]) mm[wi][b*8 +: 8] = wd[b*8 +: 8];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
  endtask

  task automatic clear_q();
    exp_i.delete(); act_i.delete(); exp_d.delete(); act_d.delete();
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (instr_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_irvalid: got %b want 0", instr_rvalid_o); end
    n_cmp++; if (data_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_drvalid: got %b want 0", data_rvalid_o); end
    n_cmp++; if (instr_rdata_o !== '0) begin n_fail++; $display("FAIL reset_irdata: got %h want 0", instr_rdata_o); end
    n_cmp++; if (data_rdata_o !== '0) begin n_fail++; $display("FAIL reset_drdata: got %h want 0", data_rdata_o); end
    instr_req_i = 1'b1; data_req_i = 1'b1; stall_en_i = 1'b1;
    #1;
    n_cmp++; if (instr_gnt_o !== 1'b1) begin n_fail++; $display("FAIL reset_ignt_req1: got %b want 1", instr_gnt_o); end
    n_cmp++; if (data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL reset_dgnt_req1: got %b want 1", data_gnt_o); end
    instr_req_i = 1'b0; data_req_i = 1'b0; stall_en_i = 1'b0;
    #1;
    n_cmp++; if (instr_gnt_o !== 1'b0 || data_gnt_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_gnt_req0: got %b%b want 00", instr_gnt_o, data_gnt_o);
    end
    @(negedge clk); rstn_i = 1'b1;
    idle(4);
    n_cmp++; if (act_i.size() + act_d.size() != 0) begin
      n_fail++; $display("FAIL reset_no_resp: got %0d responses want 0", act_i.size() + act_d.size());
    end
  endtask

  task automatic preload();
    for (int w = 0; w < 256; w++) drive(1'b0, 16'h0, 1'b1, 1'b1, 4'hF, 16'(w * 4), $urandom);
    idle(4);
    clear_q();
  endtask

  task automatic test_write_read();
    int c0;
    clear_q();
    drive(1'b0, 16'h0, 1'b1, 1'b1, 4'hF, 16'h0100, 32'hDEADBEEF);
    c0 = cyc;
    drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0100, 32'h0);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 4'b0001, 16'h0100, 32'h000000AA);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0102, 32'h0);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 4'hF, 16'hFFFC, 32'hCAFEF00D);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'hFFFD, 32'h0);
    idle(6);
    n_cmp++; if (act_d.size() != 6) begin n_fail++; $display("FAIL wr_count: got %0d want 6", act_d.size()); end
    if (act_d.size() == 6) begin
      n_cmp++; if (act_d[0].dat !== 128'h0) begin n_fail++; $display("FAIL wr_write_rdata: got %h want 0", act_d[0].dat); end
      n_cmp++; if (act_d[0].cyc != c0 + DL) begin n_fail++; $display("FAIL wr_latency: got cyc %0d want %0d", act_d[0].cyc, c0 + DL); end
      n_cmp++; if (act_d[1].dat[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_full_word: got %h want deadbeef", act_d[1].dat[31:0]); end
      n_cmp++; if (act_d[1].cyc != c0 + DL + 1) begin n_fail++; $display("FAIL wr_b2b_cyc: got %0d want %0d", act_d[1].cyc, c0 + DL + 1); end
      n_cmp++; if (act_d[3].dat[31:0] !== 32'hDEADBEAA) begin n_fail++; $display("FAIL wr_byte_en: got %h want deadbeaa", act_d[3].dat[31:0]); end
      n_cmp++; if (act_d[5].dat[31:0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wr_top_addr: got %h want cafef00d", act_d[5].dat[31:0]); end
    end
    n_cmp++; if (act_i.size() != 0) begin n_fail++; $display("FAIL wr_no_ifetch: got %0d want 0", act_i.size()); end
  endtask

  task automatic test_instr_b2b();
    int c0;
    logic [127:0] b80, b90;
    clear_q();
    b80 = {mm[35], mm[34], mm[33], mm[32]};
    b90 = {mm[39], mm[38], mm[37], mm[36]};
    drive(1'b1, 16'h0080, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    c0 = cyc;
    drive(1'b1, 16'h0090, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    drive(1'b1, 16'h009C, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    idle(6);
    n_cmp++; if (act_i.size() != 3) begin n_fail++; $display("FAIL if_count: got %0d want 3", act_i.size()); end
    if (act_i.size() == 3) begin
      n_cmp++; if (act_i[0].cyc != c0 + IL || act_i[1].cyc != c0 + IL + 1) begin
        n_fail++; $display("FAIL if_latency: got %0d,%0d want %0d,%0d", act_i[0].cyc, act_i[1].cyc, c0 + IL, c0 + IL + 1);
      end
      n_cmp++; if (act_i[0].dat !== b80) begin n_fail++; $display("FAIL if_blk80: got %h want %h", act_i[0].dat, b80); end
      n_cmp++; if (act_i[1].dat !== b90) begin n_fail++; $display("FAIL if_blk90: got %h want %h", act_i[1].dat, b90); end
      n_cmp++; if (act_i[2].dat !== b90) begin n_fail++; $display("FAIL if_unaligned: got %h want %h", act_i[2].dat, b90); end
    end
  endtask

  task automatic test_same_cycle();
    int c1;
    logic [127:0] v;
    clear_q();
    drive(1'b0, 16'h0, 1'b1, 1'b1, 4'hF, 16'h0200, 32'h11111111);
    drive(1'b1, 16'h0200, 1'b1, 1'b1, 4'hF, 16'h0200, 32'h22222222);
    c1 = cyc;
    drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0200, 32'h0);
    idle(6);
    n_cmp++; if (act_i.size() != 1 || act_d.size() != 3) begin
      n_fail++; $display("FAIL sc_count: got %0d/%0d want 1/3", act_i.size(), act_d.size());
    end
    if (act_i.size() == 1 && act_d.size() == 3) begin
      v = act_i[0].dat;
      n_cmp++; if (v[31:0] !== 32'h11111111) begin n_fail++; $display("FAIL sc_old_value: got %h want 11111111", v[31:0]); end
      n_cmp++; if (act_i[0].cyc != c1 + IL) begin n_fail++; $display("FAIL sc_if_cyc: got %0d want %0d", act_i[0].cyc, c1 + IL); end
      v = act_d[2].dat;
      n_cmp++; if (v[31:0] !== 32'h22222222) begin n_fail++; $display("FAIL sc_new_value: got %h want 22222222", v[31:0]); end
    end
  endtask

  task automatic test_random();
    clear_q();
    spurious = 0; zero_viol = 0;
    stall_en_i = 1'b1;
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom), 16'($urandom_range(0, 1023)), 1'($urandom), 1'($urandom),
            4'($urandom), 16'($urandom_range(0, 1023)), $urandom);
    end
    idle(8);
    stall_en_i = 1'b0;
    n_cmp++; if (act_i.size() != exp_i.size()) begin n_fail++; $display("FAIL rnd_icount: got %0d want %0d", act_i.size(), exp_i.size()); end
    n_cmp++; if (act_d.size() != exp_d.size()) begin n_fail++; $display("FAIL rnd_dcount: got %0d want %0d", act_d.size(), exp_d.size()); end
    for (int k = 0; k < exp_i.size() && k < act_i.size(); k++) begin
      n_cmp++; if (act_i[k].cyc != exp_i[k].cyc || act_i[k].dat !== exp_i[k].dat) begin
        n_fail++; $display("FAIL rnd_ifetch[%0d]: got %0d/%h want %0d/%h", k, act_i[k].cyc, act_i[k].dat, exp_i[k].cyc, exp_i[k].dat);
      end
    end
    for (int k = 0; k < exp_d.size() && k < act_d.size(); k++) begin
      n_cmp++; if (act_d[k].cyc != exp_d[k].cyc || act_d[k].dat !== exp_d[k].dat) begin
        n_fail++; $display("FAIL rnd_data[%0d]: got %0d/%h want %0d/%h", k, act_d[k].cyc, act_d[k].dat[31:0], exp_d[k].cyc, exp_d[k].dat[31:0]);
      end
    end
    n_cmp++; if (spurious != 0) begin n_fail++; $display("FAIL rnd_gnt_no_req: got %0d want 0", spurious); end
    n_cmp++; if (zero_viol != 0) begin n_fail++; $display("FAIL rnd_rdata_idle_zero: got %0d want 0", zero_viol); end
  endtask

  task automatic test_stall();
    int ilo, ihi;
    clear_q();
    ireq_cnt = 0; dreq_cnt = 0; ignt_cnt = 0; dgnt_cnt = 0;
    stall_en_i = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 16'($urandom_range(0, 1023)), 1'b1, 1'b0, 4'h0, 16'($urandom_range(0, 1023)), 32'h0);
    end
    idle(8);
`ifdef DP_RAM_RANDOM_STALL_EN
    ilo = 700; ihi = 800;
`else
    ilo = 1000; ihi = 1000;
`endif
    n_cmp++; if (ignt_cnt * 1000 / ireq_cnt < ilo || ignt_cnt * 1000 / ireq_cnt > ihi) begin
      n_fail++; $display("FAIL stall_irate: got %0d/%0d want %0d..%0d permille", ignt_cnt, ireq_cnt, ilo, ihi);
    end
    n_cmp++; if (dgnt_cnt * 1000 / dreq_cnt < ilo || dgnt_cnt * 1000 / dreq_cnt > ihi) begin
      n_fail++; $display("FAIL stall_drate: got %0d/%0d want %0d..%0d permille", dgnt_cnt, dreq_cnt, ilo, ihi);
    end
    n_cmp++; if (act_i.size() != ignt_cnt || act_d.size() != dgnt_cnt) begin
      n_fail++; $display("FAIL stall_answered: got %0d/%0d want %0d/%0d", act_i.size(), act_d.size(), ignt_cnt, dgnt_cnt);
    end
    stall_en_i = 1'b0;
    ireq_cnt = 0; dreq_cnt = 0; ignt_cnt = 0; dgnt_cnt = 0;
    for (int i = 0; i < 100; i++) drive(1'b1, 16'h0040, 1'b1, 1'b0, 4'h0, 16'h0040, 32'h0);
    idle(8);
    n_cmp++; if (ignt_cnt != 100 || dgnt_cnt != 100) begin
      n_fail++; $display("FAIL stall_off_full_grant: got %0d/%0d want 100/100", ignt_cnt, dgnt_cnt);
    end
    clear_q();
  endtask

  task automatic test_reset_inflight();
    clear_q();
    drive(1'b1, 16'h0040, 1'b1, 1'b0, 4'h0, 16'h0044, 32'h0);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0048, 32'h0);
    @(posedge clk); #1;
    instr_req_i = 1'b0; data_req_i = 1'b0;
    n_cmp++; if (data_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rif_pre_rvalid: got %b want 1", data_rvalid_o); end
    rstn_i = 1'b0;
    #1;
    n_cmp++; if (data_rvalid_o !== 1'b0 || data_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL rif_async_clear: got %b/%h want 0/0", data_rvalid_o, data_rdata_o);
    end
    n_cmp++; if (instr_rvalid_o !== 1'b0 || instr_rdata_o !== '0) begin
      n_fail++; $display("FAIL rif_async_iclear: got %b/%h want 0/0", instr_rvalid_o, instr_rdata_o);
    end
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    idle(8);
    n_cmp++; if (act_i.size() + act_d.size() != 0) begin
      n_fail++; $display("FAIL rif_discarded: got %0d responses want 0", act_i.size() + act_d.size());
    end
    clear_q();
  endtask

  initial begin
    test_reset();
    preload();
    test_write_read();
    test_instr_b2b();
    test_same_cycle();
    test_random();
    test_stall();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
